// File: rtl/issue_scoreboard_if.sv
// ID-stage handshake between the decode stage and the issue scoreboard.
interface issue_scoreboard_if;
  logic        id_valid;
  logic        id_is_mul;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs2;
  logic        id_writes_rd;
  logic        issue;
  logic        stall;
  logic        issue_to_mul;
  logic        issue_to_alu;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_from_mul;
  logic [31:0] pending;

  modport master (
    output id_valid, id_is_mul, id_rs1, id_rs2, id_rd, id_uses_rs2, id_writes_rd,
    input  issue, stall, issue_to_mul, issue_to_alu,
    input  wb_valid, wb_rd, wb_from_mul, pending
  );

  modport slave (
    input  id_valid, id_is_mul, id_rs1, id_rs2, id_rd, id_uses_rs2, id_writes_rd,
    output issue, stall, issue_to_mul, issue_to_alu,
    output wb_valid, wb_rd, wb_from_mul, pending
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue controller: per-register pending bits plus a writeback
// reservation shift register arbitrating one shared register-file write port
// between a single-cycle ALU and a MUL_LAT-cycle pipelined multiplier.
module issue_scoreboard #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  issue_scoreboard_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       from_mul;
  } slot_t;

  slot_t       slot_q [1:MUL_LAT];
  slot_t       slot_d [1:MUL_LAT];
  slot_t       new_slot;
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        rd_live;
  logic        raw;
  logic        waw;
  logic        structural;
  logic        issue_ok;

  // A register retiring this cycle counts as available (write-port forwarding).
  function automatic logic src_hazard(input logic [4:0] r);
    return (r != 5'd0) && pending_q[r] && !(slot_q[1].valid && (slot_q[1].rd == r));
  endfunction

  // Hazard detection, issue decision and next-state of slots and pending bits.
  always_comb begin
    rd_live    = bus.id_writes_rd && (bus.id_rd != 5'd0);
    raw        = src_hazard(bus.id_rs1) || (bus.id_uses_rs2 && src_hazard(bus.id_rs2));
    waw        = bus.id_writes_rd && src_hazard(bus.id_rd);
    // An ALU result lands in slot 1 on the same edge slot 2 shifts down into it.
    structural = !bus.id_is_mul && slot_q[2].valid;
    issue_ok   = bus.id_valid && !raw && !waw && !structural;

    new_slot = '0;
    if (rd_live) begin
      new_slot.valid    = 1'b1;
      new_slot.rd       = bus.id_rd;
      new_slot.from_mul = bus.id_is_mul;
    end

    for (int unsigned k = 1; k < MUL_LAT; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[MUL_LAT] = '0;
    if (issue_ok && bus.id_is_mul) begin
      slot_d[MUL_LAT] = new_slot;
    end
    if (issue_ok && !bus.id_is_mul) begin
      slot_d[1] = new_slot;
    end

    // Set is applied after clear so a same-register reissue keeps the bit.
    pending_d = pending_q;
    if (slot_q[1].valid) begin
      pending_d[slot_q[1].rd] = 1'b0;
    end
    if (issue_ok && rd_live) begin
      pending_d[bus.id_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Reservation slots and pending vector; reset drops all in-flight results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k <= MUL_LAT; k++) begin
        slot_q[k] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int unsigned k = 1; k <= MUL_LAT; k++) begin
        slot_q[k] <= slot_d[k];
      end
      pending_q <= pending_d;
    end
  end

  assign bus.issue        = issue_ok;
  assign bus.stall        = bus.id_valid && !issue_ok;
  assign bus.issue_to_mul = issue_ok && bus.id_is_mul;
  assign bus.issue_to_alu = issue_ok && !bus.id_is_mul;
  assign bus.wb_valid     = slot_q[1].valid;
  assign bus.wb_rd        = slot_q[1].rd;
  assign bus.wb_from_mul  = slot_q[1].from_mul;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard at MUL_LAT = 3, 2 and 8.
module tb_issue_scoreboard;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  issue_scoreboard_if bus3 ();
  issue_scoreboard_if bus2 ();
  issue_scoreboard_if bus8 ();

  issue_scoreboard #(.MUL_LAT(3)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus3));
  issue_scoreboard #(.MUL_LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  issue_scoreboard #(.MUL_LAT(8)) u_lat8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Slide sequence: op kind, rd, rs1, rs2 and required issue cycle.
  int s_mul [7] = '{1, 0, 1, 1, 0, 0, 0};
  int s_rd  [7] = '{11, 21, 15, 17, 22, 23, 24};
  int s_rs1 [7] = '{12, 20, 11, 15, 21, 22, 22};
  int s_rs2 [7] = '{13, 0, 14, 16, 0, 0, 0};
  int s_cyc [7] = '{0, 1, 3, 6, 7, 9, 10};
  // Retiring destination per cycle (0 = no writeback) and its mux select.
  int e_wb  [13] = '{0, 0, 21, 11, 0, 0, 15, 0, 22, 17, 23, 24, 0};
  int e_wbm [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
  // Dependent multiplier pair for the latency sweep.
  int w_rd  [2] = '{4, 5};
  int w_rs1 [2] = '{1, 4};

  int   idx;
  int   i2;
  int   i8;
  logic exp_iss;
  logic exp2;
  logic exp8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive3(input logic v, input logic mul, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic wr);
    bus3.id_valid = v;   bus3.id_is_mul = mul;  bus3.id_rd = rd;
    bus3.id_rs1 = rs1;   bus3.id_rs2 = rs2;     bus3.id_uses_rs2 = u2;
    bus3.id_writes_rd = wr;
  endtask

  task automatic drive2(input logic v, input logic [4:0] rd, input logic [4:0] rs1);
    bus2.id_valid = v;   bus2.id_is_mul = 1'b1; bus2.id_rd = rd;
    bus2.id_rs1 = rs1;   bus2.id_rs2 = 5'd3;    bus2.id_uses_rs2 = 1'b1;
    bus2.id_writes_rd = 1'b1;
  endtask

  task automatic drive8(input logic v, input logic [4:0] rd, input logic [4:0] rs1);
    bus8.id_valid = v;   bus8.id_is_mul = 1'b1; bus8.id_rd = rd;
    bus8.id_rs1 = rs1;   bus8.id_rs2 = 5'd3;    bus8.id_uses_rs2 = 1'b1;
    bus8.id_writes_rd = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive3(0, 0, 0, 0, 0, 0, 0);
    drive2(0, 0, 0);
    drive8(0, 0, 0);
    rst_n = 1'b0;
    #3;
    check("rst_pending",  bus3.pending,     32'h0);
    check("rst_wb_valid", bus3.wb_valid,    0);
    check("rst_wb_rd",    bus3.wb_rd,       0);
    check("rst_wb_mul",   bus3.wb_from_mul, 0);
    check("rst_issue",    bus3.issue,       0);
    check("rst_stall",    bus3.stall,       0);
    check("rst_pend2",    bus2.pending,     32'h0);
    check("rst_pend8",    bus8.pending,     32'h0);
    step();
    rst_n = 1'b1;

    // Slide sequence
    idx = 0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (idx < 7)
        drive3(1, s_mul[idx][0], s_rd[idx][4:0], s_rs1[idx][4:0], s_rs2[idx][4:0], s_mul[idx][0], 1);
      else
        drive3(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      exp_iss = (idx < 7) && (s_cyc[idx] == cyc);
      check($sformatf("slide_issue_c%0d", cyc), bus3.issue, exp_iss);
      check($sformatf("slide_stall_c%0d", cyc), bus3.stall, (idx < 7) && !exp_iss);
      check($sformatf("slide_tomul_c%0d", cyc), bus3.issue_to_mul, exp_iss && (idx < 7) && (s_mul[idx] == 1));
      check($sformatf("slide_wbv_c%0d", cyc), bus3.wb_valid, e_wb[cyc] != 0);
      if (e_wb[cyc] != 0) begin
        check($sformatf("slide_wbrd_c%0d", cyc), bus3.wb_rd, e_wb[cyc]);
        check($sformatf("slide_wbm_c%0d", cyc), bus3.wb_from_mul, e_wbm[cyc]);
      end
      if (bus3.issue) idx++;
      step();
    end
    check("slide_drained", bus3.pending, 32'h0);

    // x0 destination and source
    drive3(1, 1, 0, 1, 2, 1, 1);
    @(negedge clk);
    check("x0_mul_issue", bus3.issue, 1);
    step();
    drive3(1, 0, 3, 0, 0, 0, 1);
    @(negedge clk);
    check("x0_pending", bus3.pending, 32'h0);
    check("x0_addi_issue", bus3.issue, 1);
    step();
    drive3(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("x0_pend_x3", bus3.pending, 32'h0000_0008);
    check("x0_wb_rd", bus3.wb_rd, 3);
    for (int n = 0; n < 4; n++) step();
    check("x0_drained", bus3.pending, 32'h0);

    // WAW on x5
    drive3(1, 1, 5, 1, 2, 1, 1);
    @(negedge clk);
    check("waw_mul_issue", bus3.issue, 1);
    step();
    drive3(1, 0, 5, 1, 0, 0, 1);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      check($sformatf("waw_issue_c%0d", cyc), bus3.issue, cyc == 3);
      check($sformatf("waw_pend_c%0d", cyc), bus3.pending, 32'h0000_0020);
      if (cyc != 3) step();
    end
    check("waw_ret_wbv", bus3.wb_valid, 1);
    check("waw_ret_rd",  bus3.wb_rd, 5);
    check("waw_ret_mul", bus3.wb_from_mul, 1);
    step();
    drive3(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("waw_pend_c4", bus3.pending, 32'h0000_0020);
    check("waw_alu_wbv", bus3.wb_valid, 1);
    check("waw_alu_mul", bus3.wb_from_mul, 0);
    step();
    @(negedge clk);
    check("waw_pend_c5", bus3.pending, 32'h0);
    step();

    // Back-to-back independent multiplies
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc < 3) drive3(1, 1, 5'(6 + cyc), 1, 2, 1, 1);
      else         drive3(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("b2b_issue_c%0d", cyc), bus3.issue, cyc < 3);
      check($sformatf("b2b_wbv_c%0d", cyc), bus3.wb_valid, (cyc >= 3) && (cyc <= 5));
      if ((cyc >= 3) && (cyc <= 5)) begin
        check($sformatf("b2b_wbrd_c%0d", cyc), bus3.wb_rd, 6 + cyc - 3);
        check($sformatf("b2b_wbm_c%0d", cyc), bus3.wb_from_mul, 1);
      end
      step();
    end

    // Reset while a multiply is in flight
    drive3(1, 1, 9, 1, 2, 1, 1);
    @(negedge clk);
    check("rmf_issue", bus3.issue, 1);
    step();
    drive3(0, 0, 0, 0, 0, 0, 0);
    check("rmf_pend_set", bus3.pending, 32'h0000_0200);
    step();
    rst_n = 1'b0;
    #1;
    check("rmf_pend_clr", bus3.pending, 32'h0);
    check("rmf_wbv_rst", bus3.wb_valid, 0);
    step();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      check($sformatf("rmf_no_wb_c%0d", cyc), bus3.wb_valid, 0);
      step();
    end
    drive3(1, 0, 10, 9, 0, 0, 1);
    @(negedge clk);
    check("rmf_dep_issue", bus3.issue, 1);
    step();
    drive3(0, 0, 0, 0, 0, 0, 0);

    // Latency sweep: dependent pair issues exactly MUL_LAT edges apart
    i2 = 0;
    i8 = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (i2 < 2) drive2(1, w_rd[i2][4:0], w_rs1[i2][4:0]); else drive2(0, 0, 0);
      if (i8 < 2) drive8(1, w_rd[i8][4:0], w_rs1[i8][4:0]); else drive8(0, 0, 0);
      @(negedge clk);
      exp2 = ((i2 == 0) && (cyc == 0)) || ((i2 == 1) && (cyc == 2));
      exp8 = ((i8 == 0) && (cyc == 0)) || ((i8 == 1) && (cyc == 8));
      check($sformatf("lat2_issue_c%0d", cyc), bus2.issue, exp2);
      check($sformatf("lat8_issue_c%0d", cyc), bus8.issue, exp8);
      if (bus2.issue) i2++;
      if (bus8.issue) i8++;
      step();
    end
    check("lat2_count", i2, 2);
    check("lat8_count", i8, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between ID and EX of the RISC-V pipeline. It tracks a pending-write bit per architectural register and sequences a single-cycle ALU and a pipelined multiplier of fixed latency MUL_LAT through one shared register-file write port. An instruction issues only when it has no RAW hazard, no WAW hazard and no write-port conflict; otherwise it stalls in ID.

## Interface
- MUL_LAT, 3: multiplier latency in cycles, legal range 2..8.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- id_valid  in  1  a decoded instruction is present in ID.
- id_is_mul  in  1  1 = multiplier op, 0 = ALU op.
- id_rs1, id_rs2, id_rd  in  5 each  register specifiers.
- id_uses_rs2  in  1  rs2 is a true source.
- id_writes_rd  in  1  the instruction writes rd.
- issue  out  1  instruction accepted at the next edge (combinational).
- stall  out  1  id_valid & ~issue (combinational); holds IF/ID.
- issue_to_mul, issue_to_alu  out  1 each  issue qualified by unit.
- wb_valid  out  1  write-port slot 1 holds a retiring result.
- wb_rd  out  5  destination of the retiring result.
- wb_from_mul  out  1  write-port mux select, 1 = multiplier.
- pending  out  32  per-register pending-write vector; bit 0 is always 0.

## Operation
- Writeback reservation shift register: slot[1..MUL_LAT], each slot holding {valid, rd, from_mul}. wb_* outputs come from slot[1] combinationally.
- On every edge: slot[k] <= slot[k+1] for k < MUL_LAT, and slot[MUL_LAT] <= empty. On top of that:
  - an issued MUL writes slot[MUL_LAT];
  - an issued ALU op writes slot[1].
- An instruction with id_writes_rd=0, or with rd=x0, reserves a slot with valid=0 and sets no pending bit.
- Source hazard on register r (r≠0): pending[r] & ~(wb_valid & wb_rd==r). A register retiring this cycle is treated as available; the datapath forwards the write-port value.
- RAW: hazard on rs1, or on rs2 when id_uses_rs2.
- WAW: id_writes_rd and hazard on rd.
- Structural conflict, ALU only: slot[2].valid. Slot[2] would shift into slot[1] on the same edge.
- issue = id_valid & ~RAW & ~WAW & ~structural. A MUL never has a structural conflict.
- Pending update on each edge:
  - bit wb_rd clears when wb_valid;
  - bit id_rd sets on issue with id_writes_rd and rd≠0;
  - set wins over clear on the same register.
- Issue is strictly in order; there is no buffering in this block.

## Timing
- Reset (asynchronous, active-low): all slots invalid, pending = 0. Consequently issue, stall, wb_valid = 0 and wb_rd = 0, wb_from_mul = 0.
- ALU issued at edge e: wb_valid is high for the cycle after e; pending clears at edge e+1.
- MUL issued at edge e: wb_valid is high for the cycle after edge e+MUL_LAT−1; pending clears at edge e+MUL_LAT.
- A dependent instruction issues at the earliest on the edge at which its producer retires; zero bubbles beyond the producer's latency.
- At most one writeback per cycle, guaranteed by the reservation check.
- Reset asserted mid-operation discards all in-flight reservations immediately; no wb_valid appears afterward.
- Inputs are sampled only when id_valid=1; other ID fields are don't-care when id_valid=0.

## Test plan
- Slide sequence, MUL_LAT=3, id_valid held, next instruction presented after each issue: mul x11,x12,x13; addi x21,x20,1; mul x15,x11,x14; mul x17,x15,x16; addi x22,x21,1; addi x23,x22,1; addi x24,x22,2. Required issue cycles are 0, 1, 3, 6, 7, 9, 10.
  - Stalls at cycles 2, 4, 5 are RAW.
  - Stall at cycle 8 is structural: x17 is in slot 2.
  - wb_rd sequence: x21@2, x11@3, x15@6, x22@8, x17@9, x23@10, x24@11.
- x0 handling: mul x0,x1,x2 followed by addi x3,x0,1 → pending stays 0 and the addi issues the next cycle.
- WAW: mul x5 followed by addi x5 → the addi stalls 2 cycles and issues at x5's retire edge. pending[5] stays set through that edge, then clears one cycle later.
- Back-to-back independent MULs on x6, x7, x8 → issue every cycle; wb_valid is high for 3 consecutive cycles with wb_from_mul=1.
- Reset mid-flight: reset low 1 cycle after a mul x9 issues → pending = 0 and slots empty. No wb_valid follows. An instruction reading x9 after reset is released issues immediately.
- Sweep MUL_LAT=2 and MUL_LAT=8 with a dependent mul pair → the second issues exactly MUL_LAT edges after the first.
